mdu: RTL and testbench
======================

# mdu

Iterative multiply/divide unit executing MULT, MULTU, DIV and DIVU. It sits in the execute stage beside the ALU and consumes the decoded multiply/divide request and the rs/rt operands. It owns the architectural HI/LO registers and serves MTHI/MTLO writes. While it is busy it tells the pipeline to stall any instruction that touches HI/LO.

## Interface
Parameters:
- none (data width fixed at 32; iteration count fixed at 32)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request a new operation; sampled only in IDLE
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- op_a  in  32  rs value (multiplicand / dividend)
- op_b  in  32  rt value (multiplier / divisor)
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- hilo_wdata  in  32  MTHI/MTLO data
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle registered pulse when a result is committed to hi/lo
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- State machine has three states: IDLE, CALC, FIX.
- **IDLE**
  - start=1: latch op, compute and latch |op_a| and |op_b| (signed ops) or raw values (unsigned ops), latch sign flags, clear the 6-bit iteration counter, go to CALC.
  - start=0: stay in IDLE.
- **CALC**
  - One iteration per cycle.
  - Multiply: shift-add over a 64-bit accumulator.
  - Divide: restoring division, one quotient bit per cycle, 33-bit trial subtract.
  - After the 32nd iteration (counter==31), go to FIX.
- **FIX**
  - Apply sign correction.
    - MULT: negate the 64-bit product if the sign of op_a differs from the sign of op_b.
    - DIV: quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - Write hi/lo:
    - Multiply: hi = product[63:32], lo = product[31:0].
    - Divide: lo = quotient, hi = remainder.
  - Assert done for the following cycle, return to IDLE.
- **Divide by zero** (op_b == 0, DIV or DIVU): lo = 32'hFFFFFFFF, hi = op_a as latched at start (original signed value). Latency is identical to a normal divide.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. This result falls out of the magnitude arithmetic; no trap is raised.
- **MTHI/MTLO**
  - In IDLE with start=0: hi_we and lo_we update hi and lo on the next edge. Both may be asserted in the same cycle.
  - In IDLE with start=1: start has priority and the HI/LO writes are dropped, because the new result will overwrite them.
  - While busy: hi_we and lo_we are ignored. The pipeline is responsible for stalling them.
- **start while busy:** ignored; no queueing.
- **Operand capture:** op_a and op_b are captured at start. Later changes to them do not affect the operation in flight.

## Timing
- **Reset:** on a clock edge with rst=1:
  - state = IDLE
  - busy = 0, done = 0
  - hi = 0, lo = 0
  - counter and internal operand/accumulator registers cleared
  - This applies mid-operation too: the operation is abandoned, no partial result is written, and done does not pulse.
- **Latency:** with start accepted at edge E0, the unit is in CALC for edges E1..E32, FIX commits at edge E33, and IDLE is re-entered at E33.
  - busy is high in the cycles after E0 through E33, i.e. 33 cycles.
  - hi/lo hold the new values and done=1 in the cycle after E33. done falls on the next edge.
- hi/lo are stable (previous values) throughout CALC; they change only at the FIX edge or on an MTHI/MTLO write.
- **Back-to-back:** start may be asserted in the same cycle that done=1, because state is already IDLE. That start is accepted.
- busy and done are driven from registered state; there is no combinational path from inputs.

## Test plan
- **MULTU** op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after the start cycle; busy high for 33 cycles.
- **MULT** op_a=0xFFFFFFFD (-3), op_b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- **DIV, negative dividend:** op_a=0xFFFFFFF9 (-7), op_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- **DIV overflow:** op_a=0x80000000, op_b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- **DIVU by zero:** op_a=7, op_b=0 -> lo=0xFFFFFFFF, hi=7, same latency.
- **Control hazards:**
  - Pulse start with different operands and assert hi_we while busy -> both ignored and the first result is unaffected.
  - MTLO 0x1234 in IDLE -> lo=0x1234 next cycle.
  - Assert rst at CALC iteration 10 -> busy=0, done never pulses, hi=lo=0.

Source files
------------

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module      : mdu
// Description : Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU.
//               It owns the architectural HI/LO registers and accepts MTHI and
//               MTLO writes while idle. A shift-add multiply or a restoring
//               divide runs for 32 iterations, followed by one sign-fix cycle.
//
// Ports       : clk        - clock; all state updates on the rising edge
//               rst        - synchronous active-high reset
//               start      - request a new operation (sampled only in IDLE)
//               op         - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//               op_a       - rs operand (multiplicand / dividend)
//               op_b       - rt operand (multiplier / divisor)
//               hi_we      - MTHI write enable (honoured only in IDLE)
//               lo_we      - MTLO write enable (honoured only in IDLE)
//               hilo_wdata - MTHI/MTLO write data
//               busy       - high whenever the unit is not IDLE
//               done       - one-cycle pulse after a result is committed
//               hi, lo     - architectural HI/LO registers
//
// Revision    : 1.0 - initial release
// ============================================================================
module mdu (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] hilo_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;

    localparam logic [5:0] c_LAST_ITER = 6'd31;

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic        r_is_div;
    logic        r_div_zero;
    logic        r_neg_res;   // result (product or quotient) must be negated
    logic        r_neg_a;     // dividend was negative: remainder takes its sign
    logic [31:0] r_orig_a;    // signed dividend, returned in HI on divide by zero
    logic [31:0] r_opnd;      // multiplicand magnitude or divisor magnitude
    logic [63:0] r_acc;       // mult: {partial product, multiplier}
                              // div : {remainder, dividend/quotient}
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    // ------------------------------------------------------------------------
    // Operand conditioning at start
    // ------------------------------------------------------------------------
    logic        w_signed_op;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;

    assign w_signed_op = ~op[0];
    assign w_a_neg     = w_signed_op & op_a[31];
    assign w_b_neg     = w_signed_op & op_b[31];
    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    assign w_a_mag     = w_a_neg ? (32'd0 - op_a) : op_a;
    assign w_b_mag     = w_b_neg ? (32'd0 - op_b) : op_b;

    // ------------------------------------------------------------------------
    // Multiply iteration: add multiplicand to the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right by one.
    // The carry out of the add becomes the new MSB.
    // ------------------------------------------------------------------------
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // ------------------------------------------------------------------------
    // Divide iteration: shift the next dividend bit into the remainder and try
    // to subtract the divisor. The shifted remainder needs 33 bits; when the
    // trial succeeds the difference is below the divisor, so 32 bits hold it.
    // ------------------------------------------------------------------------
    logic [32:0] w_div_part;
    logic        w_div_ok;
    logic [31:0] w_div_rem;
    logic [63:0] w_div_next;

    assign w_div_part = r_acc[63:31];
    assign w_div_ok   = (w_div_part >= {1'b0, r_opnd});
    assign w_div_rem  = w_div_part[31:0] - r_opnd;
    assign w_div_next = w_div_ok ? {w_div_rem, r_acc[30:0], 1'b1}
                                 : {r_acc[62:0], 1'b0};

    // ------------------------------------------------------------------------
    // Sign correction applied in FIX
    // ------------------------------------------------------------------------
    logic [63:0] w_prod_fix;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

    assign w_prod_fix = r_neg_res ? (64'd0 - r_acc) : r_acc;
    assign w_quot_fix = r_neg_res ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem_fix  = r_neg_a   ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    // ------------------------------------------------------------------------
    // State machine and architectural registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= 6'd0;
            r_is_div   <= 1'b0;
            r_div_zero <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_a    <= 1'b0;
            r_orig_a   <= 32'd0;
            r_opnd     <= 32'd0;
            r_acc      <= 64'd0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        // start wins over MTHI/MTLO: the result overwrites them.
                        r_is_div   <= op[1];
                        r_div_zero <= (op_b == 32'd0);
                        r_neg_res  <= w_a_neg ^ w_b_neg;
                        r_neg_a    <= w_a_neg;
                        r_orig_a   <= op_a;
                        r_cnt      <= 6'd0;
                        if (op[1]) begin
                            r_opnd <= w_b_mag;
                            r_acc  <= {32'd0, w_a_mag};
                        end else begin
                            r_opnd <= w_a_mag;
                            r_acc  <= {32'd0, w_b_mag};
                        end
                        r_state <= c_ST_CALC;
                    end else begin
                        if (hi_we) begin
                            r_hi <= hilo_wdata;
                        end
                        if (lo_we) begin
                            r_lo <= hilo_wdata;
                        end
                    end
                end

                c_ST_CALC: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == c_LAST_ITER) begin
                        r_state <= c_ST_FIX;
                    end
                end

                c_ST_FIX: begin
                    if (!r_is_div) begin
                        r_hi <= w_prod_fix[63:32];
                        r_lo <= w_prod_fix[31:0];
                    end else if (r_div_zero) begin
                        r_hi <= r_orig_a;
                        r_lo <= 32'hFFFF_FFFF;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quot_fix;
                    end
                    r_done  <= 1'b1;
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != c_ST_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu
// Description : Self-checking bench for mdu. A table of directed operations
//               is issued back-to-back, checking results, latency and busy
//               length. Hand-written sequences then cover start/MTHI while
//               busy, MTHI/MTLO in IDLE, start-over-MTHI priority and a
//               mid-operation reset.
//
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hilo_wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .op_a       (op_a),
        .op_b       (op_b),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .hilo_wdata (hilo_wdata),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    localparam int c_NVEC = 11;
    localparam int c_WAIT = 40;

    vec_t        vecs [c_NVEC];
    int          n_tests;
    int          n_fail;
    logic [31:0] m_hi;   // expected HI/LO contents held by the bench
    logic [31:0] m_lo;

    task automatic check(input string nm, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    // Present a start request; returns 1 ns after the accepting edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Wait (bounded) until done is seen; edges counts edges waited.
    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < c_WAIT) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    // Full operation with latency, busy-length and HI/LO-hold checks.
    task automatic do_op(input int idx, input vec_t v);
        int edges;
        int busy_cnt;
        int hold_err;
        launch(v.op, v.a, v.b);
        check("done_falls", idx, {31'd0, done}, 32'd0);
        edges    = 0;
        busy_cnt = 0;
        hold_err = 0;
        while (!done && edges < c_WAIT) begin
            if (busy) busy_cnt++;
            if (hi !== m_hi || lo !== m_lo) hold_err++;
            @(posedge clk); #1;
            edges++;
        end
        check("latency_edges", idx, edges, 33);
        check("busy_cycles", idx, busy_cnt, 33);
        check("hilo_hold", idx, hold_err, 0);
        check("hi", idx, hi, v.exp_hi);
        check("lo", idx, lo, v.exp_lo);
        m_hi = v.exp_hi;
        m_lo = v.exp_lo;
    endtask

    initial begin
        int edges;
        int done_cnt;

        n_tests = 0;
        n_fail  = 0;
        m_hi    = 32'd0;
        m_lo    = 32'd0;

        vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
        vecs[5]  = '{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[6]  = '{2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
        vecs[7]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[8]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[9]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[10] = '{2'b11, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};

        rst        = 1'b1;
        start      = 1'b0;
        op         = 2'b00;
        op_a       = 32'd0;
        op_b       = 32'd0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        hilo_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_busy", 0, {31'd0, busy}, 32'd0);
        check("rst_done", 0, {31'd0, done}, 32'd0);
        check("rst_hi", 0, hi, 32'd0);
        check("rst_lo", 0, lo, 32'd0);

        // Table vectors issued back-to-back: each start is raised in the
        // cycle where the previous done is high.
        for (int i = 0; i < c_NVEC; i++) begin
            do_op(i, vecs[i]);
        end

        // start with new operands plus MTHI/MTLO while busy: all ignored.
        launch(2'b01, 32'd3, 32'd4);
        repeat (5) begin @(posedge clk); #1; end
        start      = 1'b1;
        op         = 2'b11;
        op_a       = 32'd99;
        op_b       = 32'd3;
        hi_we      = 1'b1;
        lo_we      = 1'b1;
        hilo_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("busy_wr_hi", 0, hi, m_hi);
        check("busy_wr_lo", 0, lo, m_lo);
        wait_done(edges);
        check("hazard_done", 0, {31'd0, done}, 32'd1);
        check("hazard_hi", 0, hi, 32'd0);
        check("hazard_lo", 0, lo, 32'd12);
        m_hi = 32'd0;
        m_lo = 32'd12;
        @(posedge clk); #1;

        // MTLO alone in IDLE.
        lo_we      = 1'b1;
        hilo_wdata = 32'h0000_1234;
        @(posedge clk); #1;
        lo_we = 1'b0;
        check("mtlo_lo", 0, lo, 32'h0000_1234);
        check("mtlo_hi", 0, hi, m_hi);

        // MTHI and MTLO in the same cycle.
        hi_we      = 1'b1;
        lo_we      = 1'b1;
        hilo_wdata = 32'h5A5A_0F0F;
        @(posedge clk); #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mthilo_hi", 0, hi, 32'h5A5A_0F0F);
        check("mthilo_lo", 0, lo, 32'h5A5A_0F0F);

        // start together with MTHI: the write is dropped.
        hi_we      = 1'b1;
        hilo_wdata = 32'hFFFF_0000;
        launch(2'b01, 32'd2, 32'd3);
        hi_we = 1'b0;
        check("prio_busy", 0, {31'd0, busy}, 32'd1);
        check("prio_hi", 0, hi, 32'h5A5A_0F0F);

        // Reset at CALC iteration 10: abandoned, no done, HI/LO cleared.
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 0, {31'd0, busy}, 32'd0);
        check("midrst_hi", 0, hi, 32'd0);
        check("midrst_lo", 0, lo, 32'd0);
        done_cnt = 0;
        repeat (c_WAIT) begin
            if (done) done_cnt++;
            @(posedge clk); #1;
        end
        check("midrst_no_done", 0, done_cnt, 0);
        check("midrst_hi_after", 0, hi, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;

        // Unit recovers normally after the abandoned operation.
        do_op(100, '{2'b01, 32'd6, 32'd7, 32'd0, 32'd42});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
